inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath and PC width in bits.
REQ-002 SHALL have parameter INST_LEN, default 32, meaning instruction width in bits.
REQ-003 SHALL have parameter DEPTH, default 8, meaning entry count; legal values are powers of two, 2 or greater.
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-2, meaning the occupancy at which almost_full asserts; legal range 1..DEPTH.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit: fetch presents an entry.
REQ-008 SHALL have port in_ready, output, 1 bit: queue accepts an entry this cycle.
REQ-009 SHALL have port in_pc, input, WIDTH bits: PC of the presented instruction.
REQ-010 SHALL have port in_inst, input, INST_LEN bits: the presented instruction word.
REQ-011 SHALL have port out_valid, output, 1 bit: head entry is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: decode takes the head entry this cycle (low equals stall decode).
REQ-013 SHALL have port out_pc, output, WIDTH bits: head PC.
REQ-014 SHALL have port out_inst, output, INST_LEN bits: head instruction.
REQ-015 SHALL have port flush, input, 1 bit: branch redirect; discards all entries.
REQ-016 SHALL have port count, output, clog2(DEPTH)+1 bits: current occupancy.
REQ-017 SHALL have port almost_full, output, 1 bit: count is AF_LEVEL or greater.

Function
REQ-018 An enqueue SHALL occur when in_valid and in_ready are both high at a rising edge; a dequeue SHALL occur when out_valid and out_ready are both high at a rising edge.
REQ-019 in_ready SHALL equal (count != DEPTH), with no combinational path from out_ready, so a full queue refuses input even while it is being dequeued.
REQ-020 out_valid SHALL equal (count != 0), with no bypass: an entry enqueued at edge N SHALL first appear at the head after edge N, giving 1-cycle latency.
REQ-021 When out_valid is low, out_pc SHALL be 0 and out_inst SHALL be the NOP encoding 32'h00000013, zero-extended or truncated to INST_LEN.
REQ-022 Entries SHALL leave in FIFO order; read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-023 A simultaneous enqueue and dequeue on a non-empty, non-full queue SHALL leave count unchanged and advance both pointers.
REQ-024 Enqueue on a full queue SHALL be impossible per REQ-019; dequeue on an empty queue SHALL be ignored with no pointer or count change.
REQ-025 When flush is high at an edge, the queue SHALL become empty: pointers to 0, count to 0, and every other queue state change in that cycle ignored. Flush takes priority over enqueue and dequeue.
REQ-026 In the cycle after a flush edge, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-027 count SHALL be registered and SHALL change by +1, -1 or 0 per edge, or go to 0 on flush.
REQ-028 almost_full SHALL be derived combinationally from the registered count.

Reset
REQ-029 While reset is low, the queue SHALL immediately (asynchronously) hold pointers and count at 0, giving out_valid=0, in_ready=1, count=0, almost_full=0, out_pc=0, out_inst=NOP.
REQ-030 Storage array contents SHALL not require reset; they SHALL never be visible while their entry is invalid.
REQ-031 Reset asserted mid-operation SHALL discard all entries; the first enqueue after deassertion SHALL land in entry 0.

Structure
REQ-032 The NOP encoding constant and the default DEPTH SHALL live in the shared package cpu_pkg.
REQ-033 Storage SHALL be one sub-module, inst_queue_mem: DEPTH x (WIDTH+INST_LEN), one synchronous write port and one asynchronous read port. Pointer and count control SHALL stay in inst_queue.

Verification
REQ-034 Bench SHALL check reset: drive reset=0 mid-stream with 3 entries held -> out_valid=0, count=0 and in_ready=1 immediately, without waiting for a clock edge.
REQ-035 Bench SHALL check fill to full: hold out_ready=0 and enqueue 8 entries (PC 0x0,0x4,...,0x1C) -> count=8, in_ready=0, almost_full=1 from count=6; a 9th in_valid is not accepted.
REQ-036 Bench SHALL check drain order and wrap-around: enqueue 12 and dequeue 12 interleaved -> out_pc sequence is 0x0..0x2C in order, pointers wrap, and count ends at 0 with out_inst=0x00000013.
REQ-037 Bench SHALL check simultaneous operations: with count=4, assert in_valid and out_ready for 10 cycles -> count stays 4 and no entry is lost or duplicated.
REQ-038 Bench SHALL check flush priority: with count=5, assert flush, in_valid and out_ready in the same cycle -> next cycle count=0 and out_valid=0, and the in_pc presented that cycle never appears at out_pc.
REQ-039 Bench SHALL check latency: on an empty queue, enqueue PC 0x100 at edge N -> out_valid stays 0 before edge N, and out_pc=0x100 with out_valid=1 after edge N.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_pkg : constants shared by the front-end pipeline blocks              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package cpu_pkg;

    localparam logic [31:0] NOP_INST      = 32'h0000_0013;
    localparam int          IQ_DEPTH_DFLT = 8;

endpackage
`default_nettype wire

// File: rtl/inst_queue_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_queue_mem : DEPTH x DATA_W storage, sync write / async read port    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module inst_queue_mem #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    // No reset: contents are only observed through entries the queue marks valid.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/inst_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_queue : fetch-to-decode instruction FIFO with flush and almost_full |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module inst_queue
    import cpu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int INST_LEN = 32,
    parameter int DEPTH    = IQ_DEPTH_DFLT,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_pc,
    input  logic [INST_LEN-1:0]      in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_pc,
    output logic [INST_LEN-1:0]      out_inst,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full
);

    localparam int                    C_PTR_W    = $clog2(DEPTH);
    localparam int                    C_CNT_W    = C_PTR_W + 1;
    localparam logic [C_CNT_W-1:0]    C_FULL_CNT = C_CNT_W'(DEPTH);
    localparam logic [C_CNT_W-1:0]    C_AF_CNT   = C_CNT_W'(AF_LEVEL);
    localparam logic [INST_LEN-1:0]   C_NOP      = INST_LEN'(NOP_INST);

    logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_CNT_W-1:0] count_q,  count_d;

    logic                      w_wr_en;
    logic                      w_rd_en;
    logic [WIDTH+INST_LEN-1:0] w_rdata;

    // Handshakes depend only on registered count, never on the opposite side.
    assign in_ready    = (count_q != C_FULL_CNT);
    assign out_valid   = (count_q != '0);
    assign almost_full = (count_q >= C_AF_CNT);
    assign count       = count_q;

    assign w_wr_en = in_valid & in_ready;
    assign w_rd_en = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (w_rd_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    inst_queue_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (WIDTH + INST_LEN)
    ) u_mem (
        .clk   (clk),
        .we    (w_wr_en & ~flush),
        .waddr (wr_ptr_q),
        .wdata ({in_pc, in_inst}),
        .raddr (rd_ptr_q),
        .rdata (w_rdata)
    );

    // Empty head presents a zero PC and a NOP so stale storage never leaks out.
    assign out_pc   = out_valid ? w_rdata[WIDTH+INST_LEN-1:INST_LEN] : '0;
    assign out_inst = out_valid ? w_rdata[INST_LEN-1:0]              : C_NOP;

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_inst_queue : directed self-checking bench for inst_queue              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_inst_queue;

    localparam int WIDTH    = 32;
    localparam int INST_LEN = 32;
    localparam int DEPTH    = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_pc;
    logic [INST_LEN-1:0]    in_inst;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_pc;
    logic [INST_LEN-1:0]    out_inst;
    logic                   flush;
    logic [3:0]             count;
    logic                   almost_full;

    int n_checks = 0;
    int n_errors = 0;

    inst_queue #(
        .WIDTH    (WIDTH),
        .INST_LEN (INST_LEN),
        .DEPTH    (DEPTH),
        .AF_LEVEL (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_inst     (in_inst),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .flush       (flush),
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'hC0DE_0000 ^ pc;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst_of(pc);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_pc"},    64'(out_pc),    64'(pc));
        check({tag, "_inst"},  64'(out_inst),  64'(inst_of(pc)));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #1 reset  = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_out_valid", 64'(out_valid),   64'd0);
        check("rst_in_ready",  64'(in_ready),    64'd1);
        check("rst_count",     64'(count),       64'd0);
        check("rst_af",        64'(almost_full), 64'd0);
        check("rst_out_pc",    64'(out_pc),      64'd0);
        check("rst_out_inst",  64'(out_inst),    64'h13);
        reset = 1'b1;
        tick();

        // One-cycle latency, no bypass
        in_valid = 1'b1;
        in_pc    = 32'h100;
        in_inst  = inst_of(32'h100);
        #1;
        check("lat_pre_valid", 64'(out_valid), 64'd0);
        check("lat_pre_pc",    64'(out_pc),    64'd0);
        tick();
        in_valid = 1'b0;
        check("lat_post_valid", 64'(out_valid), 64'd1);
        check("lat_post_pc",    64'(out_pc),    64'h100);
        pop_check("lat_pop", 32'h100);
        check("lat_count", 64'(count), 64'd0);

        // Fill to full with decode stalled
        for (int i = 0; i < 8; i++) begin
            push(32'(4 * i));
            check("fill_count", 64'(count),       64'(i + 1));
            check("fill_af",    64'(almost_full), 64'((i + 1) >= 6));
        end
        check("full_in_ready", 64'(in_ready), 64'd0);
        push(32'h20);
        check("full_9th_count", 64'(count),  64'd8);
        check("full_head_pc",   64'(out_pc), 64'h0);
        for (int i = 0; i < 8; i++) begin
            pop_check("full_drain", 32'(4 * i));
        end
        check("full_drain_count", 64'(count), 64'd0);

        // Interleaved enqueue/dequeue with pointer wrap
        for (int i = 0; i < 6; i++) begin
            push(32'(4 * i));
        end
        for (int k = 0; k < 6; k++) begin
            check("wrap_mid_pc", 64'(out_pc), 64'(4 * k));
            in_valid  = 1'b1;
            in_pc     = 32'(4 * (6 + k));
            in_inst   = inst_of(in_pc);
            out_ready = 1'b1;
            tick();
            check("wrap_mid_count", 64'(count), 64'd6);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 6; k < 12; k++) begin
            pop_check("wrap_tail", 32'(4 * k));
        end
        check("wrap_end_count", 64'(count),     64'd0);
        check("wrap_end_valid", 64'(out_valid), 64'd0);
        check("wrap_end_inst",  64'(out_inst),  64'h13);

        // Simultaneous enqueue and dequeue at count 4
        for (int i = 0; i < 4; i++) begin
            push(32'h200 + 32'(4 * i));
        end
        for (int k = 0; k < 10; k++) begin
            check("sim_head_pc", 64'(out_pc), 64'(32'h200 + 32'(4 * k)));
            in_valid  = 1'b1;
            in_pc     = 32'h210 + 32'(4 * k);
            in_inst   = inst_of(in_pc);
            out_ready = 1'b1;
            tick();
            check("sim_count", 64'(count), 64'd4);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 10; k < 14; k++) begin
            pop_check("sim_tail", 32'h200 + 32'(4 * k));
        end
        check("sim_end_count", 64'(count), 64'd0);

        // Flush beats simultaneous enqueue and dequeue
        for (int i = 0; i < 5; i++) begin
            push(32'h300 + 32'(4 * i));
        end
        check("fl_pre_count", 64'(count), 64'd5);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'hBAD0;
        in_inst   = inst_of(32'hBAD0);
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("fl_count",    64'(count),     64'd0);
        check("fl_valid",    64'(out_valid), 64'd0);
        check("fl_in_ready", 64'(in_ready),  64'd1);
        check("fl_out_pc",   64'(out_pc),    64'd0);
        push(32'h400);
        check("fl_after_count", 64'(count), 64'd1);
        pop_check("fl_after", 32'h400);
        check("fl_after_empty", 64'(out_valid), 64'd0);

        // Asynchronous reset with 3 entries held
        for (int i = 0; i < 3; i++) begin
            push(32'h500 + 32'(4 * i));
        end
        check("ar_pre_count", 64'(count), 64'd3);
        #2 reset = 1'b0;
        #1;
        check("ar_valid",    64'(out_valid), 64'd0);
        check("ar_count",    64'(count),     64'd0);
        check("ar_in_ready", 64'(in_ready),  64'd1);
        check("ar_out_pc",   64'(out_pc),    64'd0);
        tick();
        reset = 1'b1;
        tick();
        push(32'h600);
        push(32'h604);
        check("ar_post_count", 64'(count), 64'd2);
        check("ar_post_wr_ptr", 64'(dut.wr_ptr_q), 64'd2);
        pop_check("ar_post", 32'h600);
        pop_check("ar_post", 32'h604);
        check("ar_post_end", 64'(count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
